// File: rtl/rx_stat_pkg.sv
// Shared constants and FSM encoding for the rx statistics counter store.
package rx_stat_pkg;

    localparam int unsigned NUM_CNT = 18;
    localparam int unsigned IDX_W   = 5;

    localparam int unsigned CNT_FRAMES_OK = 0;
    localparam int unsigned CNT_FCS_ERR   = 1;
    localparam int unsigned CNT_ALIGN_ERR = 2;
    localparam int unsigned CNT_BCAST     = 3;
    localparam int unsigned CNT_MCAST     = 4;
    localparam int unsigned CNT_PAUSE     = 5;
    localparam int unsigned CNT_UNDERSIZE = 6;
    localparam int unsigned CNT_OVERSIZE  = 7;
    localparam int unsigned CNT_FRAGMENT  = 8;
    localparam int unsigned CNT_JABBER    = 9;
    localparam int unsigned CNT_LEN_ERR   = 10;
    localparam int unsigned CNT_SYM_ERR   = 11;
    localparam int unsigned CNT_DROP      = 12;
    localparam int unsigned CNT_VLAN      = 13;
    localparam int unsigned CNT_CTRL      = 14;
    localparam int unsigned CNT_UNSUP_OP  = 15;
    localparam int unsigned CNT_RUNT      = 16;
    localparam int unsigned CNT_BYTES     = 17;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_UPD,
        ST_HRD
    } state_e;

endpackage

// File: rtl/rx_stat_ram.sv
// Single-port counter RAM, synchronous read with one cycle latency.
// Contents are undefined until the controller zero-fills them.
module rx_stat_ram #(
    parameter int unsigned DEPTH = 18,
    parameter int unsigned WIDTH = 48,
    parameter int unsigned AW    = 5
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rx_stat_counter_ctrl.sv
// Collects rx statistic pulses in small accumulators and folds them into the
// counter RAM by read-modify-write, sharing the RAM with host reads.
module rx_stat_counter_ctrl
    import rx_stat_pkg::*;
#(
    parameter int unsigned CNT_W     = 48,
    parameter int unsigned ACC_W     = 10,
    parameter int unsigned CLR_ON_RD = 0
) (
    input  logic               rxclk,
    input  logic               reset,
    input  logic [NUM_CNT-1:0] stat_inc,
    input  logic [3:0]         rx_bytes,
    input  logic               host_rd_req,
    input  logic [IDX_W-1:0]   host_rd_addr,
    output logic               host_rd_valid,
    output logic [CNT_W-1:0]   host_rd_data,
    output logic               init_done,
    output logic               acc_ovf
);

    localparam int unsigned SW = ACC_W + 1;
    localparam int unsigned PW = IDX_W + 1;

    state_e             state_q;
    logic [IDX_W-1:0]   init_idx_q, rr_q, upd_addr_q, hrd_addr_q;
    logic               last_hrd_q, hrd_ok_q;
    logic [CNT_W-1:0]   snap_q, data_q;
    logic               valid_q, init_done_q, ovf_q;
    logic [ACC_W-1:0]   acc_q [NUM_CNT];
    logic [ACC_W-1:0]   acc_d [NUM_CNT];

    logic               pick_vld, host_go, upd_go, host_addr_ok, ovf_set;
    logic [IDX_W-1:0]   pick_idx;
    logic [PW-1:0]      cand;
    logic [SW-1:0]      inc, sum;
    logic               ram_en, ram_we;
    logic [IDX_W-1:0]   ram_addr;
    logic [CNT_W-1:0]   ram_wdata, ram_rdata;

    // Round-robin: first nonzero accumulator at or after rr_q, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_CNT; k++) begin
            cand = {1'b0, rr_q} + PW'(k);
            if (cand >= PW'(NUM_CNT)) begin
                cand = cand - PW'(NUM_CNT);
            end
            if (!pick_vld && acc_q[cand[IDX_W-1:0]] != '0) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    // A host read yields to pending updates only right after another host read.
    assign host_go      = (state_q == ST_IDLE) && host_rd_req && (!last_hrd_q || !pick_vld);
    assign upd_go       = (state_q == ST_IDLE) && !host_go && pick_vld;
    assign host_addr_ok = host_rd_addr < IDX_W'(NUM_CNT);

    always_comb begin
        ovf_set = 1'b0;
        inc     = '0;
        sum     = '0;
        acc_d   = '{default: '0};
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (i == CNT_BYTES) begin
                inc = stat_inc[i] ? SW'(rx_bytes) : '0;
            end else begin
                inc = SW'(stat_inc[i]);
            end
            if (upd_go && pick_idx == IDX_W'(i)) begin
                sum = inc;
            end else begin
                sum = SW'(acc_q[i]) + inc;
            end
            if (sum[ACC_W]) begin
                acc_d[i] = '1;
                ovf_set  = 1'b1;
            end else begin
                acc_d[i] = sum[ACC_W-1:0];
            end
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            ST_INIT: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = init_idx_q;
            end
            ST_IDLE: begin
                if (host_go && host_addr_ok) begin
                    ram_en   = 1'b1;
                    ram_addr = host_rd_addr;
                end else if (upd_go) begin
                    ram_en   = 1'b1;
                    ram_addr = pick_idx;
                end
            end
            ST_UPD: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = upd_addr_q;
                ram_wdata = ram_rdata + snap_q;
            end
            ST_HRD: begin
                if (CLR_ON_RD != 0 && hrd_ok_q) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = hrd_addr_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            rr_q        <= '0;
            upd_addr_q  <= '0;
            hrd_addr_q  <= '0;
            last_hrd_q  <= 1'b0;
            hrd_ok_q    <= 1'b0;
            snap_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                acc_q[i] <= acc_d[i];
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            valid_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    init_idx_q <= init_idx_q + IDX_W'(1);
                    if (init_idx_q == IDX_W'(NUM_CNT - 1)) begin
                        init_done_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (host_go) begin
                        hrd_addr_q <= host_rd_addr;
                        hrd_ok_q   <= host_addr_ok;
                        last_hrd_q <= 1'b1;
                        state_q    <= ST_HRD;
                    end else if (upd_go) begin
                        upd_addr_q <= pick_idx;
                        snap_q     <= CNT_W'(acc_q[pick_idx]);
                        rr_q       <= (pick_idx == IDX_W'(NUM_CNT - 1)) ? '0 : pick_idx + IDX_W'(1);
                        last_hrd_q <= 1'b0;
                        state_q    <= ST_UPD;
                    end
                end
                ST_UPD: state_q <= ST_IDLE;
                ST_HRD: begin
                    data_q  <= hrd_ok_q ? ram_rdata : '0;
                    valid_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    rx_stat_ram #(
        .DEPTH (NUM_CNT),
        .WIDTH (CNT_W),
        .AW    (IDX_W)
    ) u_ram (
        .clk_i   (rxclk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign host_rd_valid = valid_q;
    assign host_rd_data  = data_q;
    assign init_done     = init_done_q;
    assign acc_ovf       = ovf_q;

endmodule

// File: tb/tb_rx_stat_counter_ctrl.sv
// Directed bench: a default instance plus a clear-on-read, 3-bit-accumulator instance.
module tb_rx_stat_counter_ctrl;
    import rx_stat_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] stat_inc = '0;
    logic [3:0]  rx_bytes = '0;
    logic        rd_req = 1'b0;
    logic [4:0]  rd_addr = '0;

    logic        a_valid, a_done, a_ovf;
    logic [47:0] a_data;
    logic        c_valid, c_done, c_ovf;
    logic [47:0] c_data;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned model [18];

    always #5 clk = ~clk;

    rx_stat_counter_ctrl dut (
        .rxclk(clk), .reset(rst_n), .stat_inc(stat_inc), .rx_bytes(rx_bytes),
        .host_rd_req(rd_req), .host_rd_addr(rd_addr), .host_rd_valid(a_valid),
        .host_rd_data(a_data), .init_done(a_done), .acc_ovf(a_ovf)
    );

    rx_stat_counter_ctrl #(.ACC_W(3), .CLR_ON_RD(1)) dut_c (
        .rxclk(clk), .reset(rst_n), .stat_inc(stat_inc), .rx_bytes(rx_bytes),
        .host_rd_req(rd_req), .host_rd_addr(rd_addr), .host_rd_valid(c_valid),
        .host_rd_data(c_data), .init_done(c_done), .acc_ovf(c_ovf)
    );

    typedef struct {
        logic [17:0] inc;
        logic [3:0]  bytes;
        int unsigned cycles;
        logic [4:0]  addr;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [17:0] inc, input logic [3:0] b, input int unsigned n);
        for (int unsigned c = 0; c < n; c++) begin
            stat_inc = inc;
            rx_bytes = b;
            for (int unsigned i = 0; i < 17; i++) if (inc[i]) model[i]++;
            if (inc[17]) model[17] += b;
            tick();
        end
        stat_inc = '0;
        rx_bytes = '0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned c = 0; c < n; c++) tick();
    endtask

    // Issue one host read to the chosen instance and check data and latency.
    task automatic rd_check(input bit sel, input logic [4:0] addr, input logic [47:0] exp, input string name);
        bit got = 1'b0;
        int unsigned lat = 0;
        logic [47:0] data = '0;
        rd_req  = 1'b1;
        rd_addr = addr;
        for (int unsigned n = 1; n <= 64 && !got; n++) begin
            tick();
            if (sel ? c_valid : a_valid) begin
                got  = 1'b1;
                lat  = n;
                data = sel ? c_data : a_data;
            end
        end
        rd_req = 1'b0;
        check({name, "_seen"}, 64'(got), 64'd1);
        check({name, "_data"}, 64'(data), 64'(exp));
        check({name, "_lat"}, 64'(lat), 64'd2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned nvalid;

        for (int unsigned i = 0; i < 18; i++) model[i] = 0;

        vecs[0]  = '{18'h00001 << CNT_FRAMES_OK, 4'd0, 100, 5'(CNT_FRAMES_OK), 48'd100};
        vecs[1]  = '{(18'h1 << CNT_BYTES) | (18'h1 << CNT_MCAST), 4'd8, 50, 5'(CNT_BYTES), 48'd400};
        vecs[2]  = '{18'h0, 4'd0, 0, 5'(CNT_MCAST), 48'd50};
        vecs[3]  = '{18'h1 << CNT_BYTES, 4'd0, 20, 5'(CNT_BYTES), 48'd400};
        vecs[4]  = '{(18'h1 << CNT_BYTES) | (18'h1 << CNT_FCS_ERR), 4'd3, 7, 5'(CNT_BYTES), 48'd421};
        vecs[5]  = '{18'h0, 4'd0, 0, 5'(CNT_FCS_ERR), 48'd7};
        vecs[6]  = '{18'h1 << CNT_ALIGN_ERR, 4'd8, 5, 5'(CNT_BYTES), 48'd421};
        vecs[7]  = '{18'h0, 4'd0, 0, 5'(CNT_ALIGN_ERR), 48'd5};
        vecs[8]  = '{18'h1 << CNT_RUNT, 4'd0, 33, 5'(CNT_RUNT), 48'd33};
        vecs[9]  = '{18'h0, 4'd0, 0, 5'd25, 48'd0};
        vecs[10] = '{18'h00001, 4'd0, 1, 5'(CNT_FRAMES_OK), 48'd101};

        // Reset state
        idle(3);
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_data", 64'(a_data), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_ovf", 64'(a_ovf), 64'd0);
        rst_n = 1'b1;
        n = 0;
        while (!a_done && n < 100) begin
            tick();
            n++;
        end
        check("init_cycles", 64'(n), 64'd18);
        rd_check(1'b0, 5'd0, 48'd0, "first_rd");

        for (int unsigned v = 0; v < 11; v++) begin
            drive(vecs[v].inc, vecs[v].bytes, vecs[v].cycles);
            idle(60);
            rd_check(1'b0, vecs[v].addr, vecs[v].exp, $sformatf("vec%0d", v));
        end
        check("ovf_light", 64'(a_ovf), 64'd0);

        // Read data holds and valid is a single pulse
        tick();
        check("valid_pulse", 64'(a_valid), 64'd0);
        check("data_hold", 64'(a_data), 64'd101);

        // Host request held continuously while every counter pulses
        rd_addr = 5'd5;
        rd_req  = 1'b1;
        nvalid  = 0;
        for (int unsigned c = 0; c < 200; c++) begin
            stat_inc = '1;
            rx_bytes = 4'd1;
            for (int unsigned i = 0; i < 18; i++) model[i]++;
            tick();
            if (a_valid) nvalid++;
        end
        stat_inc = '0;
        rx_bytes = '0;
        rd_req   = 1'b0;
        check("alt_rd_low", 64'(nvalid >= 45), 64'd1);
        check("alt_rd_high", 64'(nvalid <= 55), 64'd1);
        idle(100);
        for (int unsigned i = 0; i < 18; i++) begin
            rd_check(1'b0, 5'(i), 48'(model[i]), $sformatf("all_cnt%0d", i));
        end
        check("ovf_busy", 64'(a_ovf), 64'd0);

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        check("arst_data", 64'(a_data), 64'd0);
        check("arst_done", 64'(a_done), 64'd0);
        check("arst_ovf_c", 64'(c_ovf), 64'd0);
        tick();
        rst_n = 1'b1;
        n = 0;
        while (!c_done && n < 100) begin
            tick();
            n++;
        end
        check("c_init", 64'(c_done), 64'd1);

        // Clear-on-read instance
        drive(18'h1 << CNT_BCAST, 4'd0, 10);
        idle(60);
        rd_check(1'b1, 5'(CNT_BCAST), 48'd10, "clr_rd1");
        rd_check(1'b1, 5'(CNT_BCAST), 48'd0, "clr_rd2");
        drive(18'h1 << CNT_BCAST, 4'd0, 5);
        idle(60);
        rd_check(1'b1, 5'(CNT_BCAST), 48'd5, "clr_rd3");
        check("c_ovf_light", 64'(c_ovf), 64'd0);

        // Starved 3-bit accumulators must saturate; wide ones must not
        rd_addr = 5'd7;
        rd_req  = 1'b1;
        for (int unsigned c = 0; c < 100; c++) begin
            stat_inc = '1;
            rx_bytes = 4'd8;
            tick();
        end
        stat_inc = '0;
        rx_bytes = '0;
        rd_req   = 1'b0;
        check("c_ovf_set", 64'(c_ovf), 64'd1);
        check("a_ovf_clear", 64'(a_ovf), 64'd0);
        idle(60);
        check("c_ovf_sticky", 64'(c_ovf), 64'd1);
        rd_check(1'b1, 5'd25, 48'd0, "oob_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_stat_counter_ctrl.md
Name: rx_stat_counter_ctrl

Overview:
Scheduler and arbiter for the receive statistics counter store. It takes the registered per-cycle increment vector from the rx statistics block (18 one-cycle pulses plus a byte count) and collects them in small per-counter pending accumulators. It sequences read-modify-write updates into a single-port counter RAM, and shares that RAM with host read requests. It sits between the rx statistics pulse output and the management/host register interface.

Parameters:
NUM_CNT, 18, number of statistics counters; RAM depth; index 17 is the byte counter
CNT_W, 48, width of each stored counter; wraps modulo 2^CNT_W
ACC_W, 10, width of each pending accumulator
CLR_ON_RD, 0, when 1 a host read zeroes the stored counter

Ports:
rxclk  in  1  single clock for the block
reset  in  1  asynchronous, active-low reset
stat_inc  in  18  one-cycle increment pulses; bit i adds 1 to counter i, except bit 17
rx_bytes  in  4  byte count 0..8; added to counter 17 in any cycle where stat_inc[17]=1
host_rd_req  in  1  read request; held high with stable host_rd_addr until host_rd_valid
host_rd_addr  in  5  counter index
host_rd_valid  out  1  one-cycle pulse; host_rd_data is valid in that cycle
host_rd_data  out  CNT_W  stored counter value
init_done  out  1  high once RAM zero-fill is complete
acc_ovf  out  1  sticky; set when any accumulator saturates

Behaviour:
- Reset (reset=0, asynchronous): state=INIT, init index=0, all accumulators=0, rr pointer=0. Outputs host_rd_valid=0, host_rd_data=0, init_done=0, acc_ovf=0.
- Accumulators are updated every cycle in every state:
  - Index i<17 adds stat_inc[i].
  - Index 17 adds rx_bytes when stat_inc[17]=1.
  - Each accumulator saturates at 2^ACC_W-1. Saturation sets acc_ovf, which clears only on reset.
- FSM states: INIT, IDLE, UPD, HRD.
- INIT: writes 0 to RAM addresses 0..NUM_CNT-1, one per cycle (18 cycles). Then init_done=1 and state=IDLE. Accumulators keep collecting during INIT.
- IDLE arbitration, in priority order:
  - (a) host_rd_req=1 and the previous operation was not a host read: issue RAM read of host_rd_addr, go to HRD.
  - (b) any accumulator nonzero: the round-robin pick is the first nonzero index at or after the rr pointer, wrapping.
    - Issue RAM read of that index.
    - Snapshot its accumulator into a CNT_W-wide increment.
    - Clear the accumulator; any same-cycle increment becomes its new value.
    - rr pointer = pick+1, wrapping at NUM_CNT. Go to UPD.
  - (c) host_rd_req=1 (back-to-back host read when no update is pending): as (a).
- UPD (1 cycle): RAM read data is available. Write read data + snapshot (mod 2^CNT_W) to the same address. Return to IDLE. Each update is 2 cycles.
- HRD (1 cycle): RAM read data is available.
  - host_rd_data <= read data. host_rd_valid pulses in the following cycle; data is held until the next read.
  - If CLR_ON_RD=1, write 0 to the address. The pending accumulator is not cleared and is applied later.
  - Return to IDLE.
- Host value excludes pending accumulator contents; the maximum staleness is 2*NUM_CNT+2 cycles.
- host_rd_addr >= NUM_CNT: no RAM access. Returns data 0 with valid after the same latency. No write, even when CLR_ON_RD=1.
- Host read latency from IDLE with the request present: request seen at cycle 0, host_rd_valid at cycle 2.
- Requests during INIT are held off until init_done.
- Throughput: worst-case service interval per counter is 2*NUM_CNT plus interleaved host reads. This is below 2^ACC_W / 8 cycles at default parameters, so saturation indicates a misconfiguration.

Decomposition:
- Shared package rx_stat_pkg holds:
  - counter index constants (CNT_FRAMES_OK=0, CNT_FCS_ERR=1 … CNT_BYTES=17)
  - NUM_CNT
  - FSM state encoding.
- Sub-module rx_stat_ram: single-port, NUM_CNT x CNT_W, synchronous read with 1-cycle latency, write-enable. Contents are undefined after reset, which is why INIT zero-fill is required.

Test Plan:
- Release reset, idle inputs -> init_done rises at cycle 18. A host read of index 0 returns 0 with host_rd_valid 2 cycles after the request.
- Pulse stat_inc[0] for 100 consecutive cycles, wait 40 cycles, read index 0 -> 100.
- stat_inc[17]=1 with rx_bytes=8 for 50 cycles plus stat_inc[4] pulses every cycle -> counter 17 reads 400 and counter 4 reads 50. No acc_ovf.
- Hold host_rd_req continuously while all 18 stat bits pulse every cycle -> host reads alternate with updates. After inputs stop, every counter equals its pulse count.
- CLR_ON_RD=1: 10 increments to index 3, read -> 10. Immediately read again -> 0. Then 5 increments and a read -> 5.
- Force ACC_W=3 and host_rd_req held to starve updates -> acc_ovf=1 and stays 1. host_rd_addr=25 -> data 0 and valid pulse.
